// File: rtl/vp_key_event_queue_if.sv
// Key event queue bus: raw PS/2 and numpad inputs, decoded ASCII event outputs.
interface vp_key_event_queue_if;
   logic [10:0] ps2_key;
   logic [9:0]  joy_numpad;
   logic        rx_data_ready;
   logic [7:0]  rx_ascii;
   logic        rx_released;
   logic        overflow;

   modport master (
      output ps2_key, joy_numpad,
      input  rx_data_ready, rx_ascii, rx_released, overflow
   );

   modport slave (
      input  ps2_key, joy_numpad,
      output rx_data_ready, rx_ascii, rx_released, overflow
   );
endinterface

// File: rtl/vp_key_event_queue.sv
// Merges PS/2 key events and numpad button edges into one ASCII event FIFO,
// delivered as single-cycle strobes separated by a fixed idle gap.
module vp_key_event_queue #(
   parameter int DEPTH      = 8,
   parameter int GAP_CYCLES = 16
) (
   input logic                  clk_sys,
   input logic                  reset,
   vp_key_event_queue_if.slave  bus
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_PRESENT, ST_GAP} state_t;

   // Returns {valid, ascii}; the extended-key flag plays no part in the mapping.
   function automatic logic [8:0] map_scancode(input logic [7:0] code);
      case (code)
         8'h16: return {1'b1, 8'h31};
         8'h1E: return {1'b1, 8'h32};
         8'h26: return {1'b1, 8'h33};
         8'h25: return {1'b1, 8'h34};
         8'h2E: return {1'b1, 8'h35};
         8'h36: return {1'b1, 8'h36};
         8'h3D: return {1'b1, 8'h37};
         8'h3E: return {1'b1, 8'h38};
         8'h46: return {1'b1, 8'h39};
         8'h45: return {1'b1, 8'h30};
         8'h1C: return {1'b1, 8'h61};
         8'h32: return {1'b1, 8'h62};
         8'h21: return {1'b1, 8'h63};
         8'h23: return {1'b1, 8'h64};
         8'h24: return {1'b1, 8'h65};
         8'h2B: return {1'b1, 8'h66};
         8'h34: return {1'b1, 8'h67};
         8'h33: return {1'b1, 8'h68};
         8'h43: return {1'b1, 8'h69};
         8'h3B: return {1'b1, 8'h6A};
         8'h42: return {1'b1, 8'h6B};
         8'h4B: return {1'b1, 8'h6C};
         8'h3A: return {1'b1, 8'h6D};
         8'h31: return {1'b1, 8'h6E};
         8'h44: return {1'b1, 8'h6F};
         8'h4D: return {1'b1, 8'h70};
         8'h15: return {1'b1, 8'h71};
         8'h2D: return {1'b1, 8'h72};
         8'h1B: return {1'b1, 8'h73};
         8'h2C: return {1'b1, 8'h74};
         8'h3C: return {1'b1, 8'h75};
         8'h2A: return {1'b1, 8'h76};
         8'h1D: return {1'b1, 8'h77};
         8'h22: return {1'b1, 8'h78};
         8'h35: return {1'b1, 8'h79};
         8'h1A: return {1'b1, 8'h7A};
         8'h29: return {1'b1, 8'h20};
         8'h79: return {1'b1, 8'h2B};
         8'h7B: return {1'b1, 8'h2D};
         8'h7C: return {1'b1, 8'h2A};
         8'h4A: return {1'b1, 8'h2F};
         8'h55: return {1'b1, 8'h3D};
         8'h1F: return {1'b1, 8'h11};
         8'h27: return {1'b1, 8'h12};
         8'h5A: return {1'b1, 8'h0A};
         8'h66: return {1'b1, 8'h08};
         default: return 9'h000;
      endcase
   endfunction

   logic [9:0]       ps2_s;        // {toggle, press, scancode}
   logic             ps2_tog_q;
   logic [9:0]       joy_s, joy_q;
   logic [9:0]       pend_press_q, pend_release_q, pend_press_d, pend_release_d;
   logic [8:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   state_t           state_q, state_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic [7:0]       ascii_q;
   logic             released_q, overflow_q;

   logic [8:0]       ps2_map, wr_data;
   logic [7:0]       joy_ascii;
   logic [3:0]       joy_gnt_idx;
   logic             ps2_wr, pop, can_write, joy_wr, wr_en;
   logic             joy_gnt_valid, joy_gnt_release;
   logic             ext_flag_unused;

   assign ext_flag_unused = bus.ps2_key[8];

   // Inputs are re-registered every cycle; during reset the history copies load
   // the live inputs so held keys or buttons do not look like fresh events.
   // NOTE: sequential state uses <= so every flop samples pre-edge values, no ordering races.
   always_ff @(posedge clk_sys) begin
      ps2_s <= {bus.ps2_key[10:9], bus.ps2_key[7:0]};
      joy_s <= bus.joy_numpad;
      if (reset) begin
         ps2_tog_q <= bus.ps2_key[10];
         joy_q     <= bus.joy_numpad;
      end else begin
         ps2_tog_q <= ps2_s[9];
         joy_q     <= joy_s;
      end
   end

   assign ps2_map   = map_scancode(ps2_s[7:0]);
   assign ps2_wr    = (ps2_s[9] ^ ps2_tog_q) & ps2_map[8];
   assign pop       = (state_q == ST_IDLE) && (count_q != '0);
   assign can_write = (count_q != CNT_W'(DEPTH)) || pop;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      joy_gnt_valid   = 1'b0;
      joy_gnt_release = 1'b0;
      joy_gnt_idx     = '0;
      for (int i = 9; i >= 0; i--) begin
         if (pend_release_q[i] || pend_press_q[i]) begin
            joy_gnt_valid   = 1'b1;
            joy_gnt_release = pend_release_q[i];
            joy_gnt_idx     = 4'(i);
         end
      end
   end

   assign joy_ascii = (joy_gnt_idx == 4'd9) ? 8'h30 : 8'h31 + {4'h0, joy_gnt_idx};
   assign joy_wr    = joy_gnt_valid & ~ps2_wr & can_write;
   assign wr_en     = (ps2_wr & can_write) | joy_wr;
   assign wr_data   = ps2_wr ? {~ps2_s[8], ps2_map[7:0]} : {joy_gnt_release, joy_ascii};

   // A served flag clears first; a fresh edge then overrides so only the latest level queues.
   always_comb begin
      pend_press_d   = pend_press_q;
      pend_release_d = pend_release_q;
      if (joy_wr) begin
         if (joy_gnt_release) pend_release_d[joy_gnt_idx] = 1'b0;
         else                 pend_press_d[joy_gnt_idx]   = 1'b0;
      end
      for (int i = 0; i < 10; i++) begin
         if (joy_s[i] && !joy_q[i]) begin
            pend_press_d[i]   = 1'b1;
            pend_release_d[i] = 1'b0;
         end else if (!joy_s[i] && joy_q[i]) begin
            pend_release_d[i] = 1'b1;
            pend_press_d[i]   = 1'b0;
         end
      end
   end

   // NOTE: storage has no reset; only pointers and count define which entries are live.
   always_ff @(posedge clk_sys) begin
      if (wr_en && !reset) mem[wr_ptr_q] <= wr_data;
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         pend_press_q   <= '0;
         pend_release_q <= '0;
         ascii_q        <= 8'h00;
         released_q     <= 1'b0;
         overflow_q     <= 1'b0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop) begin
            rd_ptr_q                <= rd_ptr_q + 1'b1;
            {released_q, ascii_q}   <= mem[rd_ptr_q];
         end
         case ({wr_en, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         if (ps2_wr && !can_write) overflow_q <= 1'b1;
         pend_press_q   <= pend_press_d;
         pend_release_q <= pend_release_d;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         gap_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         gap_cnt_q <= gap_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      gap_cnt_d = '0;
      case (state_q)
         ST_IDLE:    if (pop) state_d = ST_PRESENT;
         ST_PRESENT: state_d = ST_GAP;
         ST_GAP: begin
            if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) state_d = ST_IDLE;
            else                                      gap_cnt_d = gap_cnt_q + 1'b1;
         end
         default:    state_d = ST_IDLE;
      endcase
   end

   assign bus.rx_data_ready = (state_q == ST_PRESENT);
   assign bus.rx_ascii      = ascii_q;
   assign bus.rx_released   = released_q;
   assign bus.overflow      = overflow_q;
endmodule

// File: tb/tb_vp_key_event_queue.sv
// Self-checking bench for vp_key_event_queue: mapping table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_vp_key_event_queue;
   localparam int DEPTH = 8;
   localparam int GAP   = 16;

   typedef struct {
      logic [7:0] code;
      logic       press;
      logic       mapped;
      logic [7:0] ascii;
   } vec_t;

   localparam logic [7:0] LETTER_CODES [26] = '{
      8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A,
      8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
   localparam logic [7:0] DIGIT_CODES [10] = '{
      8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
   localparam logic [7:0] SYM_CODES [10] = '{
      8'h29, 8'h79, 8'h7B, 8'h7C, 8'h4A, 8'h55, 8'h1F, 8'h27, 8'h5A, 8'h66};
   localparam logic [7:0] SYM_ASCII [10] = '{
      8'h20, 8'h2B, 8'h2D, 8'h2A, 8'h2F, 8'h3D, 8'h11, 8'h12, 8'h0A, 8'h08};

   logic clk_sys = 1'b0;
   logic reset   = 1'b1;
   int   errors  = 0;
   int   checks  = 0;
   int   cyc     = 0;

   always #5 clk_sys = ~clk_sys;

   vp_key_event_queue_if bus ();

   vp_key_event_queue #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .bus     (bus)
   );

   // Reference model: two-edge input delay line, one pending level per numpad key,
   // an event queue and a countdown until the next delivery is allowed.
   logic [10:0] m_ps2_s;
   logic        m_tog_o;
   logic [9:0]  m_joy_s, m_joy_o;
   logic [8:0]  m_fifo [$];
   int          m_pend [10];
   int          m_wait;
   logic        m_rdy, m_rel, m_ovf;
   logic [7:0]  m_ascii;

   logic [8:0]  got_q [$];
   int          got_cyc [$];

   function automatic logic [7:0] digit_ascii(input int i);
      return (i == 9) ? 8'h30 : 8'(8'h31 + i);
   endfunction

   function automatic logic [8:0] ref_map(input logic [7:0] code);
      for (int i = 0; i < 26; i++) if (LETTER_CODES[i] == code) return {1'b1, 8'(8'h61 + i)};
      for (int i = 0; i < 10; i++) if (DIGIT_CODES[i] == code) return {1'b1, digit_ascii(i)};
      for (int i = 0; i < 10; i++) if (SYM_CODES[i] == code) return {1'b1, SYM_ASCII[i]};
      return 9'h000;
   endfunction

   function automatic logic pend_empty();
      for (int i = 0; i < 10; i++) if (m_pend[i] >= 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_edge();
      logic       ps2_busy;
      logic [8:0] m;
      int         gi;
      if (reset) begin
         m_fifo.delete();
         for (int i = 0; i < 10; i++) m_pend[i] = -1;
         m_wait  = 0;
         m_rdy   = 1'b0;
         m_rel   = 1'b0;
         m_ovf   = 1'b0;
         m_ascii = 8'h00;
         m_ps2_s = bus.ps2_key;
         m_tog_o = bus.ps2_key[10];
         m_joy_s = bus.joy_numpad;
         m_joy_o = bus.joy_numpad;
      end else begin
         m_rdy = 1'b0;
         if (m_wait == 0 && m_fifo.size() > 0) begin
            {m_rel, m_ascii} = m_fifo.pop_front();
            m_rdy  = 1'b1;
            m_wait = GAP + 1;
         end else if (m_wait > 0) begin
            m_wait--;
         end
         ps2_busy = 1'b0;
         if (m_ps2_s[10] != m_tog_o) begin
            m = ref_map(m_ps2_s[7:0]);
            if (m[8]) begin
               ps2_busy = 1'b1;
               if (m_fifo.size() < DEPTH) m_fifo.push_back({~m_ps2_s[9], m[7:0]});
               else                       m_ovf = 1'b1;
            end
         end
         if (!ps2_busy && m_fifo.size() < DEPTH) begin
            gi = -1;
            for (int i = 9; i >= 0; i--) if (m_pend[i] >= 0) gi = i;
            if (gi >= 0) begin
               m_fifo.push_back({1'(m_pend[gi] == 0), digit_ascii(gi)});
               m_pend[gi] = -1;
            end
         end
         for (int i = 0; i < 10; i++) if (m_joy_s[i] != m_joy_o[i]) m_pend[i] = m_joy_s[i] ? 1 : 0;
         m_tog_o = m_ps2_s[10];
         m_joy_o = m_joy_s;
         m_ps2_s = bus.ps2_key;
         m_joy_s = bus.joy_numpad;
      end
   endtask

   task automatic step();
      @(posedge clk_sys);
      model_edge();
      #1;
      cyc++;
      check("cycle", 32'({bus.rx_data_ready, bus.rx_released, bus.overflow, bus.rx_ascii}),
                     32'({m_rdy, m_rel, m_ovf, m_ascii}));
      if (bus.rx_data_ready === 1'b1) begin
         got_q.push_back({bus.rx_released, bus.rx_ascii});
         got_cyc.push_back(cyc);
      end
   endtask

   task automatic drain();
      int n = 0;
      do begin
         step();
         n++;
      end while (!(n >= 3 && m_wait == 0 && m_fifo.size() == 0 && pend_empty()) && n < 400);
   endtask

   task automatic send_ps2(input logic [7:0] code, input logic press);
      bus.ps2_key = {~bus.ps2_key[10], press, 1'($urandom_range(1)), code};
   endtask

   function automatic logic [31:0] got_at(input int i);
      return (i < got_q.size()) ? 32'(got_q[i]) : 32'h1FF;
   endfunction

   initial begin
      vec_t vecs [18];
      int   n;
      logic [7:0] code;

      vecs[0]  = '{8'h1C, 1'b1, 1'b1, 8'h61};
      vecs[1]  = '{8'h1C, 1'b0, 1'b1, 8'h61};
      vecs[2]  = '{8'h1A, 1'b1, 1'b1, 8'h7A};
      vecs[3]  = '{8'h16, 1'b1, 1'b1, 8'h31};
      vecs[4]  = '{8'h45, 1'b0, 1'b1, 8'h30};
      vecs[5]  = '{8'h29, 1'b1, 1'b1, 8'h20};
      vecs[6]  = '{8'h79, 1'b1, 1'b1, 8'h2B};
      vecs[7]  = '{8'h7B, 1'b0, 1'b1, 8'h2D};
      vecs[8]  = '{8'h7C, 1'b1, 1'b1, 8'h2A};
      vecs[9]  = '{8'h4A, 1'b1, 1'b1, 8'h2F};
      vecs[10] = '{8'h55, 1'b1, 1'b1, 8'h3D};
      vecs[11] = '{8'h1F, 1'b1, 1'b1, 8'h11};
      vecs[12] = '{8'h27, 1'b0, 1'b1, 8'h12};
      vecs[13] = '{8'h5A, 1'b1, 1'b1, 8'h0A};
      vecs[14] = '{8'h66, 1'b1, 1'b1, 8'h08};
      vecs[15] = '{8'h05, 1'b1, 1'b0, 8'h00};
      vecs[16] = '{8'h4B, 1'b1, 1'b1, 8'h6C};
      vecs[17] = '{8'h3E, 1'b1, 1'b1, 8'h38};

      bus.ps2_key    = '0;
      bus.joy_numpad = '0;
      reset = 1'b1;
      repeat (2) step();
      check("rst_ready",    32'(bus.rx_data_ready), 0);
      check("rst_ascii",    32'(bus.rx_ascii), 0);
      check("rst_released", 32'(bus.rx_released), 0);
      check("rst_overflow", 32'(bus.overflow), 0);

      // Inputs already active while reset is held must not produce events.
      bus.ps2_key    = {1'b1, 1'b1, 1'b0, 8'h1C};
      bus.joy_numpad = 10'h008;
      repeat (2) step();
      reset = 1'b0;
      got_q.delete();
      drain();
      check("held_no_event", got_q.size(), 0);
      bus.joy_numpad = 10'h000;
      drain();
      check("held_release_cnt", got_q.size(), 1);
      check("held_release_val", got_at(0), 'h134);

      // Three edges from toggle to strobe.
      got_q.delete();
      send_ps2(8'h1C, 1'b1);
      step();
      check("lat_e0", 32'(bus.rx_data_ready), 0);
      step();
      check("lat_e1", 32'(bus.rx_data_ready), 0);
      step();
      check("lat_e2_ready", 32'(bus.rx_data_ready), 1);
      check("lat_e2_ascii", 32'(bus.rx_ascii), 'h61);
      check("lat_e2_rel",   32'(bus.rx_released), 0);
      drain();

      for (int v = 0; v < 18; v++) begin
         got_q.delete();
         send_ps2(vecs[v].code, vecs[v].press);
         drain();
         check($sformatf("tbl%0d_count", v), got_q.size(), vecs[v].mapped ? 1 : 0);
         if (vecs[v].mapped)
            check($sformatf("tbl%0d_event", v), got_at(0), 32'({~vecs[v].press, vecs[v].ascii}));
         check($sformatf("tbl%0d_ovf", v), 32'(bus.overflow), 0);
      end

      // Ten events on consecutive clocks: nine fit (one popped early), tenth overflows.
      got_q.delete();
      got_cyc.delete();
      for (int i = 0; i < 10; i++) begin
         send_ps2(LETTER_CODES[i], 1'b1);
         step();
      end
      check("burst_ovf_before", 32'(bus.overflow), 0);
      drain();
      check("burst_count", got_q.size(), 9);
      for (int i = 0; i < 9; i++) check($sformatf("burst_order%0d", i), got_at(i), 'h061 + i);
      for (int i = 0; i + 1 < got_cyc.size(); i++)
         check($sformatf("burst_period%0d", i), got_cyc[i + 1] - got_cyc[i], GAP + 2);
      check("burst_ovf_after", 32'(bus.overflow), 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("ovf_cleared", 32'(bus.overflow), 0);
      drain();

      // Numpad "1" and "0" together, then both released.
      got_q.delete();
      bus.joy_numpad = 10'h201;
      drain();
      bus.joy_numpad = 10'h000;
      drain();
      check("joy_count", got_q.size(), 4);
      check("joy_ev0", got_at(0), 'h031);
      check("joy_ev1", got_at(1), 'h030);
      check("joy_ev2", got_at(2), 'h131);
      check("joy_ev3", got_at(3), 'h130);

      // PS/2 and numpad in the same clock: PS/2 first, numpad held not lost.
      got_q.delete();
      send_ps2(8'h5A, 1'b1);
      bus.joy_numpad = 10'h010;
      drain();
      check("coll_count", got_q.size(), 2);
      check("coll_ev0", got_at(0), 'h00A);
      check("coll_ev1", got_at(1), 'h035);

      // Reset in the middle of the gap with numpad "3" held.
      got_q.delete();
      bus.joy_numpad = 10'h014;
      n = 0;
      while (bus.rx_data_ready !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      check("gap_strobe_seen", 32'(bus.rx_data_ready), 1);
      repeat (4) step();
      reset = 1'b1;
      repeat (2) step();
      reset = 1'b0;
      step();
      check("gap_rst_no_strobe", 32'(bus.rx_data_ready), 0);
      drain();
      check("gap_rst_count", got_q.size(), 1);
      check("gap_rst_ev0", got_at(0), 'h033);
      bus.joy_numpad = 10'h010;
      drain();
      check("gap_rel_count", got_q.size(), 2);
      check("gap_rel_ev1", got_at(1), 'h133);

      // Randomized traffic, checked every cycle against the model.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(3) == 0) begin
            case ($urandom_range(3))
               0:       code = 8'($urandom_range(255));
               1:       code = LETTER_CODES[$urandom_range(25)];
               2:       code = DIGIT_CODES[$urandom_range(9)];
               default: code = SYM_CODES[$urandom_range(9)];
            endcase
            send_ps2(code, 1'($urandom_range(1)));
         end
         if ($urandom_range(7) == 0) begin
            n = $urandom_range(9);
            bus.joy_numpad[n] = ~bus.joy_numpad[n];
         end
         reset = ($urandom_range(400) == 0);
         step();
      end
      reset = 1'b0;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
